// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch stage and its instruction queue.
//   DEFAULT_RESET_PC : fetch address used after reset unless overridden
//   WORD_INC         : byte increment from one instruction word to the next
//   fetch_state_t    : fetch FSM encoding (IDLE, REQ, WAIT, DROP)
package cpu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WORD_INC         = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_queue.sv
// instr_queue: small synchronous FIFO of {pc, instr} pairs between the
// fetch FSM and decode. The head entry is read straight out of the storage
// flops, so head_pc/head_instr are register outputs.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   push, push_pc,
//   push_instr        : write one entry (caller guarantees a free slot,
//                       or a simultaneous pop when full)
//   pop               : drop the head entry (caller guarantees non-empty)
//   flush             : empty the queue; overrides push and pop
//   full, empty       : occupancy flags
//   free_count        : number of unused entries
//   head_pc,
//   head_instr        : oldest entry
module instr_queue
    import cpu_pkg::*;
#(
    parameter  int QDEPTH = 2,
    localparam int AW     = $clog2(QDEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [31:0]   push_pc,
    input  logic [31:0]   push_instr,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   free_count,
    output logic [31:0]   head_pc,
    output logic [31:0]   head_instr
);

    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(QDEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [31:0]   mem_pc    [QDEPTH];
    logic [31:0]   mem_instr [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // QDEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_pc[wr_ptr]    <= push_pc;
                mem_instr[wr_ptr] <= push_instr;
                wr_ptr            <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign free_count = DEPTH_C - count;
    assign head_pc    = mem_pc[rd_ptr];
    assign head_instr = mem_instr[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the fetch PC, requests words
// from instruction memory one at a time, buffers them in instr_queue and
// presents the oldest one with its PC to decode. PCsrc/Result redirect
// fetch, flush the queue and discard any in-flight response.
//
// Optional feature: define FETCH_ALIGN_CHECK_EN to flag redirect targets
// with Result[1:0] != 0 on the sticky fetch_fault output. Undefined, the
// check logic is absent and fetch_fault is tied low.
//
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   imem_req, imem_addr   : request to instruction memory
//   imem_gnt              : request accepted this cycle
//   imem_rvalid,
//   imem_rdata            : in-order response word
//   PCsrc, Result         : redirect strobe and target
//   instr_valid,
//   instr_ready           : handshake with decode
//   Instr, instr_pc       : head instruction word and its address
//   pc_plus8              : instr_pc + 8 (R15 read value)
//   fetch_fault           : sticky misaligned-redirect flag
//   fetch_state           : current fetch FSM state (debug observation)
//
// Handshakes: decode consumes the head entry on any rising edge where
// instr_valid && instr_ready are both high; instr_valid never depends on
// instr_ready. Memory accepts the request on a rising edge where
// imem_req && imem_gnt; imem_addr is held until then. Exactly one response
// follows each grant, and its slot is reserved at grant time so a response
// is never refused.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        PCsrc,
    input  logic [31:0] Result,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] Instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus8,
    output logic        fetch_fault,
    output logic [1:0]  fetch_state
);

    localparam int          QAW      = $clog2(QDEPTH);
    localparam logic [QAW:0] FREE_ONE = (QAW + 1)'(1);

    fetch_state_t state, state_nxt;
    logic [31:0]  fpc, fpc_nxt;
    logic [31:0]  target;

    logic         q_push, q_pop, q_flush;
    logic         q_full, q_empty;
    logic [QAW:0] q_free;
    logic         slot_left;

    assign target = {Result[31:2], 2'b00};

    // A redirect wins over both push and pop in the same cycle.
    assign q_flush = PCsrc;
    assign q_pop   = instr_valid && instr_ready && !PCsrc;
    assign q_push  = (state == WAIT) && imem_rvalid && !PCsrc;

    // A push consumes the slot reserved at grant; another request may be
    // issued only if a further slot is free after this cycle's push/pop.
    assign slot_left = (q_free > FREE_ONE) || q_pop;

    always_comb begin
        state_nxt = state;
        fpc_nxt   = fpc;
        case (state)
            IDLE: begin
                if (PCsrc) begin
                    fpc_nxt   = target;
                    state_nxt = REQ;
                end else if (!q_full) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (PCsrc) begin
                    fpc_nxt   = target;
                    // A grant in the redirect cycle still yields a stale
                    // response that has to be swallowed.
                    state_nxt = imem_gnt ? DROP : REQ;
                end else if (imem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (PCsrc) begin
                    fpc_nxt   = target;
                    state_nxt = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    fpc_nxt   = fpc + WORD_INC;
                    state_nxt = slot_left ? REQ : IDLE;
                end
            end
            DROP: begin
                if (PCsrc) begin
                    fpc_nxt = target;
                end
                if (imem_rvalid) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            fpc   <= RESET_PC;
        end else begin
            state <= state_nxt;
            fpc   <= fpc_nxt;
        end
    end

    instr_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (q_push),
        .push_pc    (fpc),
        .push_instr (imem_rdata),
        .pop        (q_pop),
        .flush      (q_flush),
        .full       (q_full),
        .empty      (q_empty),
        .free_count (q_free),
        .head_pc    (instr_pc),
        .head_instr (Instr)
    );

    assign imem_req    = (state == REQ);
    assign imem_addr   = fpc;
    assign instr_valid = !q_empty;
    assign pc_plus8    = instr_pc + 32'd8;
    assign fetch_state = state;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else if (PCsrc && (Result[1:0] != 2'b00)) begin
            fault_q <= 1'b1;
        end
    end

    assign fetch_fault = fault_q;
`else
    // Low target bits are only inspected by the alignment check.
    logic unused_low_bits;
    assign unused_low_bits = ^Result[1:0];
    assign fetch_fault     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. A per-cycle vector table
// covers the reset-release stream and the back-pressure fill; hand-written
// sequences cover redirects, wrap-around and the alignment flag. The memory
// model grants whenever enabled and returns the word address as data after
// a programmable number of extra cycles.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        PCsrc;
    logic [31:0] Result;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] Instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus8;
    logic        fetch_fault;
    logic [1:0]  fetch_state;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .PCsrc       (PCsrc),
        .Result      (Result),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .Instr       (Instr),
        .instr_pc    (instr_pc),
        .pc_plus8    (pc_plus8),
        .fetch_fault (fetch_fault),
        .fetch_state (fetch_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;

    // memory model state
    bit          gnt_en;
    int          lat;
    bit          pend;
    int          pend_wait;
    logic [31:0] pend_addr;

    // scoreboard: expected accepted instruction addresses (data == address)
    logic [31:0] exp_q[$];
    bit          sb_on;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic EXP_FAULT = 1'b1;
`else
    localparam logic EXP_FAULT = 1'b0;
`endif

    typedef struct {
        bit          rst_before;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: applies this cycle's inputs, runs the memory
    // model, scores a head entry that will be consumed, then advances to the
    // next falling edge.
    task automatic drive(input logic rdy, input logic ps, input logic [31:0] res);
        logic [31:0] e;
        instr_ready = rdy;
        PCsrc       = ps;
        Result      = res;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (pend) begin
            if (pend_wait == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_addr;
                pend        = 1'b0;
            end else begin
                pend_wait--;
            end
        end
        imem_gnt = imem_req && gnt_en;
        if (imem_gnt) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_wait = lat;
        end
        if (sb_on && instr_valid && rdy && !ps) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_word", instr_pc, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                check("sb_instr_pc", instr_pc, e);
                check("sb_instr", Instr, e);
                check("sb_pc_plus8", pc_plus8, e + 32'd8);
            end
        end
        @(negedge clk);
    endtask

    task automatic run_until_empty(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            drive(1'b1, 1'b0, 32'h0);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Assert reset for two cycles, check reset values, release at a falling
    // edge (that falling edge is cycle 0 of the following sequence).
    task automatic apply_reset();
        reset       = 1'b0;
        instr_ready = 1'b0;
        PCsrc       = 1'b0;
        Result      = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pend        = 1'b0;
        pend_wait   = 0;
        pend_addr   = 32'h0;
        gnt_en      = 1'b1;
        lat         = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_imem_req", imem_req, 0);
        check("rst_imem_addr", imem_addr, 32'h0000_0000);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_Instr", Instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_pc_plus8", pc_plus8, 8);
        check("rst_fetch_fault", fetch_fault, 0);
        check("rst_state", fetch_state, IDLE);
        reset = 1'b1;
    endtask

    function automatic vec_t mk(input bit rb, input logic rdy, input logic er,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.rst_before = rb;
        v.ready      = rdy;
        v.exp_req    = er;
        v.exp_addr   = ea;
        v.exp_valid  = ev;
        v.exp_pc     = ep;
        return v;
    endfunction

    initial begin
        // Reset release, zero-wait memory, decode always ready.
        vecs[0]  = mk(1, 1, 0, 32'h0, 0, 32'h0);
        vecs[1]  = mk(0, 1, 1, 32'h0, 0, 32'h0);
        vecs[2]  = mk(0, 1, 0, 32'h0, 0, 32'h0);
        vecs[3]  = mk(0, 1, 1, 32'h4, 1, 32'h0);
        vecs[4]  = mk(0, 1, 0, 32'h0, 0, 32'h0);
        vecs[5]  = mk(0, 1, 1, 32'h8, 1, 32'h4);
        vecs[6]  = mk(0, 1, 0, 32'h0, 0, 32'h0);
        vecs[7]  = mk(0, 1, 1, 32'hC, 1, 32'h8);
        // Decode stalled for 10 cycles: queue fills to 2, requests stop.
        vecs[8]  = mk(1, 0, 0, 32'h0, 0, 32'h0);
        vecs[9]  = mk(0, 0, 1, 32'h0, 0, 32'h0);
        vecs[10] = mk(0, 0, 0, 32'h0, 0, 32'h0);
        vecs[11] = mk(0, 0, 1, 32'h4, 1, 32'h0);
        for (int i = 12; i < 18; i++) vecs[i] = mk(0, 0, 0, 32'h0, 1, 32'h0);
        // Stall released: drain in order, fetch resumes at 8.
        vecs[18] = mk(0, 1, 0, 32'h0, 1, 32'h0);
        vecs[19] = mk(0, 1, 0, 32'h0, 1, 32'h4);
        vecs[20] = mk(0, 1, 1, 32'h8, 0, 32'h0);
        vecs[21] = mk(0, 1, 0, 32'h0, 0, 32'h0);
        vecs[22] = mk(0, 1, 1, 32'hC, 1, 32'h8);

        reset = 1'b0;
        sb_on = 1'b0;

        for (int i = 0; i < 23; i++) begin
            if (vecs[i].rst_before) apply_reset();
            check($sformatf("v%0d_imem_req", i), imem_req, vecs[i].exp_req);
            if (vecs[i].exp_req)
                check($sformatf("v%0d_imem_addr", i), imem_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_instr_valid", i), instr_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].exp_pc);
                check($sformatf("v%0d_Instr", i), Instr, vecs[i].exp_pc);
                check($sformatf("v%0d_pc_plus8", i), pc_plus8, vecs[i].exp_pc + 32'd8);
            end
            drive(vecs[i].ready, 1'b0, 32'h0);
        end

        sb_on = 1'b1;

        // Redirect while WAIT with the response still outstanding.
        apply_reset();
        lat = 3;
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(1, 0, 0);
        check("wait_state", fetch_state, WAIT);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        drive(1, 1, 32'h100);
        check("wait_redir_state", fetch_state, DROP);
        check("wait_redir_valid", instr_valid, 0);
        lat = 0;
        drive(1, 0, 0);
        drive(1, 0, 0);
        check("wait_redir_req", imem_req, 1);
        check("wait_redir_addr", imem_addr, 32'h100);
        run_until_empty(20, "wait_redir_drain");

        // Redirect in the same cycle as the grant.
        apply_reset();
        drive(1, 0, 0);
        check("gnt_redir_pre_addr", imem_addr, 32'h0);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        drive(1, 1, 32'h100);
        check("gnt_redir_state", fetch_state, DROP);
        check("gnt_redir_req", imem_req, 0);
        drive(1, 0, 0);
        check("gnt_redir_req2", imem_req, 1);
        check("gnt_redir_addr", imem_addr, 32'h100);
        run_until_empty(20, "gnt_redir_drain");

        // Redirect in WAIT with the response arriving in the same cycle.
        apply_reset();
        drive(1, 0, 0);
        drive(1, 0, 0);
        exp_q.push_back(32'h200);
        drive(1, 1, 32'h200);
        check("rv_redir_state", fetch_state, REQ);
        check("rv_redir_valid", instr_valid, 0);
        check("rv_redir_addr", imem_addr, 32'h200);
        run_until_empty(20, "rv_redir_drain");

        // Redirect from REQ without grant to the top word: wrap to 0.
        apply_reset();
        gnt_en = 1'b0;
        drive(1, 0, 0);
        drive(1, 1, 32'hFFFF_FFFC);
        check("wrap_req", imem_req, 1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        gnt_en = 1'b1;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        run_until_empty(20, "wrap_drain");

        // Misaligned redirect target: low bits cleared, optional fault flag.
        apply_reset();
        gnt_en = 1'b0;
        drive(1, 0, 0);
        drive(1, 1, 32'h102);
        check("align_fault", fetch_fault, EXP_FAULT);
        check("align_addr", imem_addr, 32'h100);
        gnt_en = 1'b1;
        exp_q.push_back(32'h100);
        run_until_empty(20, "align_drain");
        check("align_fault_sticky", fetch_fault, EXP_FAULT);
        apply_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 32-bit ARM-like core, directly upstream of the controller/datapath. Holds the fetch PC, issues word requests to instruction memory over a request/grant/response handshake, buffers returned words in a small queue, and presents `Instr` with its PC to the decode stage. Taken branches and PC writes from the condition logic (`PCsrc` with the `Result` value) redirect fetch, flush the queue and discard any in-flight response.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `QDEPTH`, 2, instruction queue entries (power of two, ≥2)

- `clk`  in  1  core clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- `imem_req`  out  1  request valid
- `imem_addr`  out  32  word-aligned fetch address, stable while `imem_req` high and `imem_gnt` low
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response word valid (≥1 cycle after grant, in order)
- `imem_rdata`  in  32  response word
- `PCsrc`  in  1  redirect strobe from condition logic
- `Result`  in  32  redirect target, sampled when `PCsrc`=1
- `instr_valid`  out  1  `Instr`/`instr_pc` valid
- `instr_ready`  in  1  decode accepts head entry
- `Instr`  out  32  head instruction word
- `instr_pc`  out  32  address of `Instr`
- `pc_plus8`  out  32  `instr_pc + 8` (ARM R15 read value)
- `fetch_fault`  out  1  sticky misaligned-target flag (see Configuration)

## Operation
- Fetch FSM: `IDLE` → `REQ` → `WAIT` → (`IDLE`|`REQ`); `DROP` for discarding.
  - `IDLE`: go `REQ` when queue free slots > 0.
  - `REQ`: `imem_req`=1, `imem_addr`=fpc; on `imem_gnt` → `WAIT`.
  - `WAIT`: on `imem_rvalid` push {fpc_issued, rdata}, fpc += 4; → `REQ` if a slot remains after push, else `IDLE`.
  - `DROP`: wait for stale `imem_rvalid`, discard it, → `REQ`.
- At most one outstanding request; a slot is reserved at grant, so a response is never refused.
- Queue pop when `instr_valid && instr_ready`; push and pop in same cycle legal when full.
- Redirect (`PCsrc`=1): fpc ← {Result[31:2],2'b00}; queue emptied; `instr_valid` low next cycle. From `WAIT` → `DROP` (unless `imem_rvalid` same cycle: that word discarded, → `REQ`). From `REQ` without grant: request withdrawn, → `REQ` with new address. From `REQ` with grant same cycle → `DROP`.
- Redirect wins over simultaneous push/pop.
- Address arithmetic mod 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `Instr`=0, `instr_pc`=0, `pc_plus8`=8, `fetch_fault`=0; FSM `IDLE`, fpc=`RESET_PC`, queue empty. Reset mid-transaction abandons it; a response arriving after release is ignored (FSM not in `WAIT`).

## Timing
- Reset release → `imem_req` high after 1 cycle (`IDLE`→`REQ`).
- Response in cycle N → `instr_valid` high in N+1 if queue was empty.
- Zero-wait memory (grant in REQ, rvalid next cycle): one instruction per 2 cycles.
- `PCsrc` in cycle N → `imem_addr`=target with `imem_req` high in N+1 (no stale response pending).
- `Instr`, `instr_pc`, `pc_plus8` are registered queue-head outputs, held while `instr_ready`=0.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: redirect with `Result[1:0]`≠0 sets `fetch_fault` (sticky until reset); redirect still proceeds with low bits cleared.
- Undefined: no check logic; `fetch_fault` tied 0.

## Structure
- Shared `cpu_pkg`: `RESET_PC` default, `fetch_state_t` enum (`IDLE`,`REQ`,`WAIT`,`DROP`), word-increment constant 4.
- Sub-module `instr_queue`: synchronous FIFO of {pc,instr}, `QDEPTH` entries, push/pop/flush, full/empty/free-count.

## Test plan
- Reset release, zero-wait memory returning `addr`: `Instr` sequence 0,4,8 with `instr_pc` 0,4,8, `pc_plus8` 8,12,16.
- `instr_ready`=0 for 10 cycles: queue fills to 2, `imem_req` drops, head stays `Instr`=0; ready=1 resumes in order.
- `PCsrc`=1, `Result`=32'h100 while in `WAIT`: stale word dropped, next `Instr` from 0x100, no word from old stream appears.
- `PCsrc` same cycle as `imem_gnt`: FSM enters `DROP`, exactly one response discarded, next fetch 0x100.
- Fetch at 32'hFFFF_FFFC: following `instr_pc` = 0.
- With `FETCH_ALIGN_CHECK_EN`, `Result`=32'h102: `fetch_fault`=1, fetch at 0x100; reset (0) clears it.
